dnn_accel_word_copier: RTL

DNN_ACCEL_WORD_COPIER -- requirements
Module: dnn_accel_word_copier

---
 rtl/dnn_accel_pkg.sv | 15 +
 rtl/dnn_accel_word_copier.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dnn_accel_pkg.sv
// Shared types and constants for the DNN accelerator word copier.
package dnn_accel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;

endpackage

// File: rtl/dnn_accel_word_copier.sv
// Word copier: moves n_words 32-bit words from src to dst over an Avalon-MM
// master, one read then one write per word, at most one read outstanding.
// Optional running checksum output enabled by macro DNN_ACCEL_WORD_COPIER_CSUM_EN.
module dnn_accel_word_copier
  import dnn_accel_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  n_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest
`ifdef DNN_ACCEL_WORD_COPIER_CSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  // Clears the byte-offset bits so every access is word aligned.
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(WORD_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [LEN_W-1:0]  i_q, i_d;
  logic [31:0]       data_q, data_d;

  logic              start_ok;
  logic              last_word;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign start_ok  = (state_q == IDLE) && start;
  assign last_word = (i_q + LEN_W'(1)) == n_q;
  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign offset    = ADDR_W'(i_q) * ADDR_W'(WORD_BYTES);
  assign rd_addr   = src_q + offset;
  assign wr_addr   = dst_q + offset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (n_words == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!m_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (m_readdatavalid) state_d = WR_REQ;
      end
      WR_REQ: begin
        if (!m_waitrequest) state_d = last_word ? DONE : RD_REQ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy         = (state_q != IDLE);
    done         = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_writedata  = '0;
    m_byteenable = '0;
    unique case (state_q)
      RD_REQ: begin
        m_read    = 1'b1;
        m_address = rd_addr;
      end
      WR_REQ: begin
        m_write      = 1'b1;
        m_address    = wr_addr;
        m_writedata  = data_q;
        m_byteenable = BE_ALL;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: latch the job on start, capture read data, advance index.
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    n_d    = n_q;
    i_d    = i_q;
    data_d = data_q;
    if (start_ok) begin
      src_d = src_addr & AlignMask;
      dst_d = dst_addr & AlignMask;
      n_d   = n_words;
      i_d   = '0;
    end
    if ((state_q == RD_WAIT) && m_readdatavalid) begin
      data_d = m_readdata;
    end
    if ((state_q == WR_REQ) && !m_waitrequest) begin
      i_d = i_q + LEN_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      n_q    <= '0;
      i_q    <= '0;
      data_q <= '0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      n_q    <= n_d;
      i_q    <= i_d;
      data_q <= data_d;
    end
  end

`ifdef DNN_ACCEL_WORD_COPIER_CSUM_EN
  logic [31:0] csum_q, csum_d;

  // Checksum next-state: cleared per job, accumulates every captured read word.
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if ((state_q == RD_WAIT) && m_readdatavalid) begin
      csum_d = csum_q + m_readdata;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

endmodule
